// File: rtl/rs_multi.sv
// rs_multi: multi-entry reservation station with CDB wakeup and age-ordered select.
//
// Holds up to RS_DEPTH renamed instructions of any FU class. Sources are woken
// by tag broadcast on the CDB. Each cycle the oldest entry that has both
// operands ready and whose FU class can accept is issued.
//
// Optional feature (macro RS_CDB_BYPASS_EN): a source whose tag matches the
// broadcast in the current cycle also counts as ready for select, so an entry
// can issue in the same cycle as its last wakeup.
//
// Ports:
//   clock, reset        clock and synchronous active-low reset
//   squash              flush all entries at the next edge
//   disp_*              dispatch request / entry contents, disp_ready = !rs_full
//   cdb_valid, cdb_tag  result tag broadcast
//   fu_ready            per-class FU accept this cycle
//   issue_*             selected entry (combinational from registered state)
//   rs_full, free_count occupancy view of the registered state
module rs_multi #(
    parameter int unsigned RS_DEPTH  = 8,
    parameter int unsigned TAG_W     = 6,
    parameter int unsigned FU_TYPES  = 4,
    parameter int unsigned PAYLOAD_W = 64,
    localparam int unsigned FU_W     = (FU_TYPES > 1) ? $clog2(FU_TYPES) : 1,
    localparam int unsigned IDX_W    = $clog2(RS_DEPTH),
    localparam int unsigned CNT_W    = $clog2(RS_DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 squash,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  logic [FU_W-1:0]      disp_fu,
    input  logic [TAG_W-1:0]     disp_T,
    input  logic [TAG_W-1:0]     disp_T1,
    input  logic [TAG_W-1:0]     disp_T2,
    input  logic                 disp_T1_rdy,
    input  logic                 disp_T2_rdy,
    input  logic [PAYLOAD_W-1:0] disp_payload,
    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [FU_TYPES-1:0]  fu_ready,
    output logic                 issue_valid,
    output logic [FU_W-1:0]      issue_fu,
    output logic [TAG_W-1:0]     issue_T,
    output logic [TAG_W-1:0]     issue_T1,
    output logic [TAG_W-1:0]     issue_T2,
    output logic [PAYLOAD_W-1:0] issue_payload,
    output logic                 rs_full,
    output logic [CNT_W-1:0]     free_count
);

    // Entry storage
    logic [RS_DEPTH-1:0]  valid;
    logic [FU_W-1:0]      fu_q      [RS_DEPTH];
    logic [TAG_W-1:0]     t_tag     [RS_DEPTH];
    logic [TAG_W-1:0]     t1_tag    [RS_DEPTH];
    logic [TAG_W-1:0]     t2_tag    [RS_DEPTH];
    logic [RS_DEPTH-1:0]  t1_rdy;
    logic [RS_DEPTH-1:0]  t2_rdy;
    logic [PAYLOAD_W-1:0] payload_q [RS_DEPTH];
    // older[i][j] = entry i was dispatched before entry j
    logic [RS_DEPTH-1:0]  older     [RS_DEPTH];

    logic [RS_DEPTH-1:0]  src1_ok;
    logic [RS_DEPTH-1:0]  src2_ok;
    logic [RS_DEPTH-1:0]  eligible;
    logic [RS_DEPTH-1:0]  sel;
    logic [IDX_W-1:0]     issue_idx;
    logic [IDX_W-1:0]     alloc_idx;
    logic                 alloc_en;
    logic                 disp_t1_hit;
    logic                 disp_t2_hit;

    // Operand readiness and eligibility per entry
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            src1_ok[i] = t1_rdy[i];
            src2_ok[i] = t2_rdy[i];
`ifdef RS_CDB_BYPASS_EN
            src1_ok[i] = t1_rdy[i] | (cdb_valid && (cdb_tag == t1_tag[i]));
            src2_ok[i] = t2_rdy[i] | (cdb_valid && (cdb_tag == t2_tag[i]));
`endif
            eligible[i] = valid[i] & src1_ok[i] & src2_ok[i] & fu_ready[fu_q[i]];
        end
    end

    // Oldest-eligible select: an entry wins when no eligible entry is older
    always_comb begin
        logic blocked;
        blocked = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            blocked = 1'b0;
            for (int k = 0; k < RS_DEPTH; k++) begin
                if (eligible[k] && older[k][i]) begin
                    blocked = 1'b1;
                end
            end
            sel[i] = eligible[i] & ~blocked;
        end
    end

    // Issue mux from the one-hot select
    always_comb begin
        issue_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (sel[i]) begin
                issue_idx = IDX_W'(i);
            end
        end
        issue_valid   = |sel;
        issue_fu      = fu_q[issue_idx];
        issue_T       = t_tag[issue_idx];
        issue_T1      = t1_tag[issue_idx];
        issue_T2      = t2_tag[issue_idx];
        issue_payload = payload_q[issue_idx];
    end

    // Occupancy and lowest-free-slot allocation
    always_comb begin
        free_count = '0;
        alloc_idx  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            free_count = free_count + CNT_W'(~valid[i]);
        end
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
        rs_full     = &valid;
        disp_ready  = ~rs_full;
        alloc_en    = disp_valid & disp_ready;
        disp_t1_hit = cdb_valid && (cdb_tag == disp_T1);
        disp_t2_hit = cdb_valid && (cdb_tag == disp_T2);
    end

    // Entry state update: wakeup, issue invalidate, allocate, squash
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (cdb_valid && (cdb_tag == t1_tag[i])) t1_rdy[i] <= 1'b1;
                if (cdb_valid && (cdb_tag == t2_tag[i])) t2_rdy[i] <= 1'b1;
            end

            if (issue_valid) begin
                valid[issue_idx] <= 1'b0;
            end

            if (squash) begin
                valid <= '0;
                for (int i = 0; i < RS_DEPTH; i++) begin
                    older[i] <= '0;
                end
            end else if (alloc_en) begin
                valid[alloc_idx]     <= 1'b1;
                fu_q[alloc_idx]      <= disp_fu;
                t_tag[alloc_idx]     <= disp_T;
                t1_tag[alloc_idx]    <= disp_T1;
                t2_tag[alloc_idx]    <= disp_T2;
                t1_rdy[alloc_idx]    <= disp_T1_rdy | disp_t1_hit;
                t2_rdy[alloc_idx]    <= disp_T2_rdy | disp_t2_hit;
                payload_q[alloc_idx] <= disp_payload;
                // Every survivor is older than the newcomer; an issuing entry is not
                for (int k = 0; k < RS_DEPTH; k++) begin
                    older[k][alloc_idx] <= valid[k] & ~(issue_valid && (issue_idx == IDX_W'(k)));
                end
                older[alloc_idx] <= '0;
            end
        end
    end

endmodule

// File: doc/rs_multi.md
Name: rs_multi

Overview:
- Parametrised multi-entry reservation station for the R10K-style out-of-order core.
- Sits between dispatch (after rename/map table) and the functional units.
- Holds RS_DEPTH entries of any FU class and wakes operands on CDB tag broadcast.
- Selects and issues the oldest ready entry whose FU class is available, one per cycle.

Parameters:
- RS_DEPTH, 8, number of entries (power of two, >=2)
- TAG_W, 6, physical register tag width
- FU_TYPES, 4, number of FU classes (e.g. 0=ALU, 1=LD, 2=ST, 3=MULT)
- PAYLOAD_W, 64, opaque decoded-instruction payload carried to issue

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- squash  in  1  flush: invalidate all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  entry available (= !rs_full)
- disp_fu  in  $clog2(FU_TYPES)  FU class
- disp_T  in  TAG_W  destination tag
- disp_T1, disp_T2  in  TAG_W  source tags
- disp_T1_rdy, disp_T2_rdy  in  1  source ready from map table (+ bit)
- disp_payload  in  PAYLOAD_W  payload
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- fu_ready  in  FU_TYPES  per-class FU can accept this cycle
- issue_valid  out  1  issue this cycle
- issue_fu  out  $clog2(FU_TYPES)  issued class
- issue_T, issue_T1, issue_T2  out  TAG_W  issued tags
- issue_payload  out  PAYLOAD_W  issued payload
- rs_full  out  1  all entries valid
- free_count  out  $clog2(RS_DEPTH)+1  number of invalid entries

Behaviour:
- Reset (reset==0 at posedge): all entries invalid, age matrix cleared. free_count=RS_DEPTH, rs_full=0, disp_ready=1, issue_valid=0. Data fields are don't-care.
- Entry state: valid, fu, T, T1, T1_rdy, T2, T2_rdy, payload.
- Age: RS_DEPTH x RS_DEPTH matrix; older[i][j]=1 means i was dispatched before j.
- Allocation: disp_valid && disp_ready writes the lowest-index invalid entry at posedge.
  - Set older[k][new]=1 for every valid k that is not leaving this cycle.
  - Clear the new row.
- disp_ready depends on registered state only. An entry freed by a same-cycle issue is not reusable until the next cycle. Dispatch when full is ignored (no write).
- Wakeup: cdb_valid && cdb_tag==Tn sets Tn_rdy for every valid entry. A source whose ready bit is already set is unaffected.
- Dispatch-time capture: if the dispatching instruction's source matches cdb_tag with cdb_valid, its rdy is stored as 1. No wakeup is ever lost.
- Eligibility: entry valid && T1_rdy && T2_rdy && fu_ready[fu]. Unused sources are dispatched with rdy=1.
- Select (combinational from registered state): choose the eligible entry with no older eligible entry. Ties are impossible by construction.
  - issue_valid=1 and issue_* driven from that entry; the entry is invalidated at posedge.
  - issue_* are don't-care when issue_valid=0.
- Issue uses no back-pressure beyond fu_ready. The FU must accept when its fu_ready bit was high.
- free_count/rs_full are registered-state views, updated the cycle after allocate/issue.
- Simultaneous allocate and issue: both occur; free_count unchanged.
- squash: at posedge all entries invalid and any same-cycle dispatch is dropped. issue_valid still reflects pre-squash state that cycle. Squash and reset behave alike except squash is not a reset.
- Reset mid-operation: all entries dropped; no issue in the cycle after reset.

Optional Feature:
- Macro: RS_CDB_BYPASS_EN.
- Defined: eligibility also counts a source as ready when cdb_valid && cdb_tag matches it that cycle. An entry waiting only on the broadcast tag issues in the broadcast cycle (back-to-back wakeup-issue).
- Undefined: wakeup is registered, so the earliest issue is the cycle after the broadcast.

Test Plan:
- Reset then idle -> free_count=8, rs_full=0, issue_valid=0.
- Dispatch 8 ops (fu=0) with T1=5 not ready, fu_ready=4'b1111 -> rs_full=1, disp_ready=0. A 9th dispatch is ignored; free_count stays 0.
- Entries waiting on tags 10 and 11 (fu=0) dispatched in order A(10), B(11); then CDB 11, next cycle CDB 10 -> B issues first. A issues the cycle after CDB 10 (one cycle earlier with RS_CDB_BYPASS_EN).
- Two ready entries of fu=1 (older X) and fu=0 (younger Y) with fu_ready=4'b0001 -> Y issues. Raise fu_ready[1] -> X issues next cycle.
- Dispatch op with T2=7 while cdb_valid, cdb_tag=7 -> entry stored ready and issues the next cycle with issue_T2=7.
- Four valid entries, assert squash with concurrent disp_valid -> next cycle free_count=8, no issue. Then assert reset low mid-stream -> identical empty state.
